// File: rtl/multiboot_scheduler.sv
// Warm-reboot arbiter: unlock key, round-robin grant, slot lookup, holdoff, ICAP pulse.
// Optional watchdog forced reboot to slot 0 is enabled by defining MBT_WATCHDOG_EN.
//
// state   | meaning
// S_IDLE  | waiting for an armed request (or watchdog expiry)
// S_HOLD  | holdoff countdown, abortable
// S_FIRE  | one-cycle reboot pulse
// S_GUARD | address held while the sequencer streams its commands
module multiboot_scheduler #(
  parameter int          NREQ         = 4,
  parameter int          HOLDOFF      = 1024,
  parameter int          GUARD        = 32,
  parameter logic [23:0] DEFAULT_ADDR = 24'h098000
`ifdef MBT_WATCHDOG_EN
  , parameter int        WD_LIMIT     = 1 << 24
`endif
) (
  input  logic              clk_icap,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_slot,
  input  logic              tbl_we,
  input  logic [2:0]        tbl_idx,
  input  logic [23:0]       tbl_addr,
  input  logic              key_we,
  input  logic [7:0]        key_data,
  input  logic              abort,
`ifdef MBT_WATCHDOG_EN
  input  logic              wd_kick,
  output logic              wd_fired,
`endif
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              armed,
  output logic              mbt_reboot,
  output logic [23:0]       mbt_spi_addr
);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMAX = (HOLDOFF > GUARD) ? HOLDOFF : GUARD;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FIRE, S_GUARD} state_t;
  typedef enum logic [1:0] {K0, K1, K_ARMED} key_t;

  state_t        state, state_nxt;
  key_t          key_st, key_nxt;
  logic [CW-1:0] tmr, tmr_nxt;
  logic [PW-1:0] ptr, winner, rr_idx;
  logic [23:0]   slot_tbl [8];
  logic          found, start_req, start_wd, tmr_zero;

  assign tmr_zero   = (tmr == '0);
  assign busy       = (state != S_IDLE);
  assign armed      = (key_st == K_ARMED);
  assign mbt_reboot = (state == S_FIRE);

  // Round-robin search starting at ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    rr_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

`ifdef MBT_WATCHDOG_EN
  localparam int WW = $clog2(WD_LIMIT + 1);
  logic [WW-1:0] wd_cnt;

  assign start_wd = (state == S_IDLE) && (wd_cnt == WW'(WD_LIMIT));

  // Counter saturates at the limit so an expiry during a busy period fires on return to IDLE.
  always_ff @(posedge clk_icap or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt   <= '0;
      wd_fired <= 1'b0;
    end else begin
      if (wd_kick || start_wd)
        wd_cnt <= '0;
      else if (wd_cnt != WW'(WD_LIMIT))
        wd_cnt <= wd_cnt + 1'b1;
      if (start_wd)
        wd_fired <= 1'b1;
    end
  end
`else
  assign start_wd = 1'b0;
`endif

  assign start_req = (state == S_IDLE) && armed && found && !start_wd;

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      S_IDLE:
        if (start_req || start_wd) begin
          state_nxt = S_HOLD;
          tmr_nxt   = CW'(HOLDOFF - 1);
        end
      S_HOLD:
        if (abort)         state_nxt = S_IDLE;
        else if (tmr_zero) state_nxt = S_FIRE;
        else               tmr_nxt   = tmr - 1'b1;
      S_FIRE: begin
        state_nxt = S_GUARD;
        tmr_nxt   = CW'(GUARD - 1);
      end
      S_GUARD:
        if (tmr_zero) state_nxt = S_IDLE;
        else          tmr_nxt   = tmr - 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Abort outranks a same-cycle key write; FIRE/GUARD ignore abort entirely.
  always_comb begin
    key_nxt = key_st;
    if ((abort && (state == S_IDLE || state == S_HOLD)) || (state == S_GUARD && tmr_zero))
      key_nxt = K0;
    else if (key_we) begin
      case (key_st)
        K0:      key_nxt = (key_data == 8'hA5) ? K1 : K0;
        K1:      key_nxt = (key_data == 8'h5A) ? K_ARMED : K0;
        default: key_nxt = key_st;
      endcase
    end
  end

  always_ff @(posedge clk_icap or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      key_st <= K0;
      tmr    <= '0;
    end else begin
      state  <= state_nxt;
      key_st <= key_nxt;
      tmr    <= tmr_nxt;
    end
  end

  always_ff @(posedge clk_icap or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= '0;
      ptr          <= '0;
      mbt_spi_addr <= DEFAULT_ADDR;
      slot_tbl[0]  <= 24'h000000;
      for (int i = 1; i < 8; i++) slot_tbl[i] <= DEFAULT_ADDR;
    end else begin
      if (tbl_we)
        slot_tbl[tbl_idx] <= tbl_addr;
      if (start_wd) begin
        grant        <= '0;
        mbt_spi_addr <= slot_tbl[0];
      end else if (start_req) begin
        grant        <= NREQ'(1) << winner;
        mbt_spi_addr <= slot_tbl[req_slot[3*winner +: 3]];
        ptr          <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
      end else if (busy && state_nxt == S_IDLE) begin
        grant <= '0;
      end
    end
  end
endmodule

// File: tb/tb_multiboot_scheduler.sv
// Scoreboard bench for multiboot_scheduler: stimulus pushes expected grants/pulses,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_multiboot_scheduler;
  localparam int          NREQ    = 4;
  localparam int          HOLDOFF = 16;
  localparam int          GUARD   = 20;
  localparam logic [23:0] DEF     = 24'h098000;
`ifdef MBT_WATCHDOG_EN
  localparam int          WD_LIMIT = 100;
`endif

  logic              clk_icap = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [3*NREQ-1:0] req_slot = '0;
  logic              tbl_we = 1'b0;
  logic [2:0]        tbl_idx = '0;
  logic [23:0]       tbl_addr = '0;
  logic              key_we = 1'b0;
  logic [7:0]        key_data = '0;
  logic              abort = 1'b0;
  logic [NREQ-1:0]   grant;
  logic              busy, armed, mbt_reboot;
  logic [23:0]       mbt_spi_addr;
`ifdef MBT_WATCHDOG_EN
  logic              wd_kick = 1'b0;
  logic              wd_fired;
  bit                wd_auto = 1'b1;
`endif

  multiboot_scheduler #(
    .NREQ(NREQ), .HOLDOFF(HOLDOFF), .GUARD(GUARD), .DEFAULT_ADDR(DEF)
`ifdef MBT_WATCHDOG_EN
    , .WD_LIMIT(WD_LIMIT)
`endif
  ) dut (
    .clk_icap(clk_icap), .rst_n(rst_n), .req(req), .req_slot(req_slot),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
    .key_we(key_we), .key_data(key_data), .abort(abort),
`ifdef MBT_WATCHDOG_EN
    .wd_kick(wd_kick), .wd_fired(wd_fired),
`endif
    .grant(grant), .busy(busy), .armed(armed),
    .mbt_reboot(mbt_reboot), .mbt_spi_addr(mbt_spi_addr)
  );

  always #5 clk_icap = ~clk_icap;

  int cyc = 0;
  always @(posedge clk_icap) cyc <= cyc + 1;

`ifdef MBT_WATCHDOG_EN
  always @(negedge clk_icap) wd_kick = wd_auto && (cyc % 50 == 0);
`endif

  typedef struct {
    logic [NREQ-1:0] g;
    logic [23:0]     a;
    int              t;   // expected cycle, -1 = don't care
  } exp_t;

  exp_t q_grant[$];
  exp_t q_boot[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic [NREQ-1:0] grant_d = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk_icap) begin
    if (grant !== '0 && grant_d === '0) begin
      if (q_grant.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_grant: got %b at cycle %0d, expected none", grant, cyc);
      end else begin
        mon_e = q_grant.pop_front();
        check("grant_value", grant, mon_e.g);
        check("grant_cycle", cyc, mon_e.t);
      end
    end
    grant_d = grant;
    if (mbt_reboot === 1'b1) begin
      if (q_boot.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_reboot: got pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_e = q_boot.pop_front();
        check("reboot_grant", grant, mon_e.g);
        check("reboot_addr", mbt_spi_addr, mon_e.a);
        if (mon_e.t >= 0) check("reboot_cycle", cyc, mon_e.t);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk_icap);
  endtask

  task automatic key_wr(logic [7:0] b);
    key_we = 1'b1; key_data = b;
    tick();
    key_we = 1'b0;
  endtask

  task automatic tbl_wr(logic [2:0] i, logic [23:0] a);
    tbl_we = 1'b1; tbl_idx = i; tbl_addr = a;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic arm();
    key_wr(8'hA5);
    key_wr(8'h5A);
  endtask

  // Request is taken at the edge following t0; pulse lands HOLDOFF cycles after the grant.
  task automatic expect_req(int t0, logic [NREQ-1:0] g, logic [23:0] a, bit with_boot);
    q_grant.push_back('{g, a, t0 + 1});
    if (with_boot) q_boot.push_back('{g, a, t0 + 1 + HOLDOFF});
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", busy, 1'b0);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_grant"}, grant, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_armed"}, armed, 1'b0);
    check({tag, "_reboot"}, mbt_reboot, 1'b0);
    check({tag, "_addr"}, mbt_spi_addr, DEF);
  endtask

  logic [23:0] rr_addr [4];
  int t0;
  bit seen_busy, seen_boot;

  initial begin
    rr_addr = '{24'h000000, 24'h111000, 24'h222000, DEF};
    tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // Locked: no key, requests ignored
    req = 4'b0001;
    seen_busy = 1'b0; seen_boot = 1'b0;
    repeat (5000) begin
      tick();
      seen_busy |= busy;
      seen_boot |= mbt_reboot;
    end
    check("locked_busy", seen_busy, 1'b0);
    check("locked_reboot", seen_boot, 1'b0);
    check("locked_grant", grant, '0);
    req = '0;

    // Unlock coinciding with req, then latency and address hold
    tbl_wr(3'd3, 24'h0B4000);
    req_slot = {3'd0, 3'd3, 3'd0, 3'd0};
    key_wr(8'hA5);
    req = 4'b0100;
    key_wr(8'h5A);
    check("unlock_armed", armed, 1'b1);
    check("unlock_same_cycle_no_grant", grant, '0);
    t0 = cyc;
    expect_req(t0, 4'b0100, 24'h0B4000, 1'b1);
    tick();
    check("grant_addr", mbt_spi_addr, 24'h0B4000);
    check("grant_busy", busy, 1'b1);
    tbl_wr(3'd3, 24'h123000);
    req = '0;
    wait_idle(HOLDOFF + GUARD + 10);
    check("idle_cycle", cyc, t0 + HOLDOFF + 2 + GUARD);
    check("after_guard_armed", armed, 1'b0);
    check("after_guard_grant", grant, '0);

    // Bad key sequence, recovery, key write while armed
    key_wr(8'hA5); key_wr(8'h11); key_wr(8'h5A);
    check("bad_key_armed", armed, 1'b0);
    arm();
    check("good_key_armed", armed, 1'b1);
    key_wr(8'h11);
    check("key_while_armed", armed, 1'b1);

    // Reset to bring the pointer to 0, then round-robin with all four held
    rst_n = 1'b0;
    tick();
    check_reset("rr_reset");
    rst_n = 1'b1;
    tbl_wr(3'd1, 24'h111000);
    tbl_wr(3'd2, 24'h222000);
    req_slot = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      arm();
      t0 = cyc;
      expect_req(t0, NREQ'(1) << k, rr_addr[k], 1'b1);
      tick();
      wait_idle(HOLDOFF + GUARD + 10);
    end
    req = '0;

    // Abort in HOLD at cycle 5, coinciding with a key write
    req = 4'b0010;
    arm();
    t0 = cyc;
    expect_req(t0, 4'b0010, 24'h111000, 1'b0);
    tick(5);
    abort = 1'b1; key_we = 1'b1; key_data = 8'hA5;
    tick();
    abort = 1'b0; key_we = 1'b0; req = '0;
    check("abort_busy", busy, 1'b0);
    check("abort_grant", grant, '0);
    check("abort_armed", armed, 1'b0);
    key_wr(8'h5A);
    check("abort_beats_key", armed, 1'b0);
    tick(HOLDOFF + GUARD + 5);

    // Reset mid-HOLD restores outputs and table
    tbl_wr(3'd3, 24'h0B4000);
    req_slot = {3'd0, 3'd3, 3'd0, 3'd0};
    req = 4'b0100;
    arm();
    t0 = cyc;
    expect_req(t0, 4'b0100, 24'h0B4000, 1'b0);
    tick(3);
    #2 rst_n = 1'b0;
    #1 check_reset("hold_reset");
    @(negedge clk_icap);
    rst_n = 1'b1;
    arm();
    t0 = cyc;
    expect_req(t0, 4'b0100, DEF, 1'b1);
    tick();
    wait_idle(HOLDOFF + GUARD + 10);

    // Reset while the pulse is high drops it at once
    arm();
    t0 = cyc;
    expect_req(t0, 4'b0100, DEF, 1'b1);
    tick(1 + HOLDOFF);
    #2 rst_n = 1'b0;
    #1 check("fire_reset_reboot", mbt_reboot, 1'b0);
    check("fire_reset_busy", busy, 1'b0);
    @(negedge clk_icap);
    rst_n = 1'b1;
    req = '0;
    tick(4);

`ifdef MBT_WATCHDOG_EN
    check("wd_kicked_not_fired", wd_fired, 1'b0);
    wd_auto = 1'b0;
    q_boot.push_back('{'0, 24'h000000, -1});
    begin
      int n = 0;
      while (busy !== 1'b1 && n < 4 * WD_LIMIT) begin
        tick();
        n++;
      end
    end
    check("wd_busy", busy, 1'b1);
    check("wd_grant", grant, '0);
    wait_idle(HOLDOFF + GUARD + 10);
    check("wd_fired", wd_fired, 1'b1);
`endif

    check("grant_queue_drained", q_grant.size(), 0);
    check("boot_queue_drained", q_boot.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
